// File: rtl/vp_pkg.sv
// Shared types and constants for the load value prediction table.
// The entry layout is fixed here, so the top-level width parameters must
// stay consistent with these localparams.
package vp_pkg;

  localparam int VP_ADDR_WIDTH  = 32;
  localparam int VP_DATA_WIDTH  = 32;
  localparam int VP_INDEX_WIDTH = 6;
  localparam int VP_CONF_WIDTH  = 2;
  localparam int VP_TAG_WIDTH   = VP_ADDR_WIDTH - VP_INDEX_WIDTH - 2;

  localparam logic [VP_CONF_WIDTH-1:0] VP_CONF_MAX = '1;

  typedef struct packed {
    logic                     valid;
    logic [VP_TAG_WIDTH-1:0]  tag;
    logic [VP_DATA_WIDTH-1:0] value;
    logic [VP_CONF_WIDTH-1:0] conf;
  } vp_entry_t;

  typedef enum logic {
    VP_IDLE,
    VP_CLEAR
  } vp_state_e;

  // Confidence increment that sticks at the maximum count.
  function automatic logic [VP_CONF_WIDTH-1:0] conf_sat_inc(input logic [VP_CONF_WIDTH-1:0] conf);
    return (conf == VP_CONF_MAX) ? conf : conf + 1'b1;
  endfunction

endpackage

// File: rtl/vp_table_ram.sv
// Entry storage for the value prediction table: one asynchronous read port,
// one synchronous write port, no reset (the clear sweep invalidates entries).
module vp_table_ram
  import vp_pkg::*;
#(
  parameter int INDEX_WIDTH = VP_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  vp_entry_t              wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output vp_entry_t              rd_data
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  vp_entry_t mem [DEPTH];

  // Single write port shared by sweep and training (muxed by the caller).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/load_value_table.sv
// PC-indexed, direct-mapped last-value prediction table with per-entry
// saturating confidence and a one-entry-per-cycle clear sweep.
// Optional feature macro: LOAD_VALUE_TABLE_BYPASS_EN forwards a same-cycle
// training update at the lookup index into the lookup response.
module load_value_table
  import vp_pkg::*;
#(
  parameter int ADDR_WIDTH  = VP_ADDR_WIDTH,
  parameter int DATA_WIDTH  = VP_DATA_WIDTH,
  parameter int INDEX_WIDTH = VP_INDEX_WIDTH,
  parameter int CONF_WIDTH  = VP_CONF_WIDTH,
  parameter int CONF_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_confident,
  output logic [DATA_WIDTH-1:0] pred_value,
  input  logic                  train_valid,
  input  logic [ADDR_WIDTH-1:0] train_pc,
  input  logic [DATA_WIDTH-1:0] train_value,
  output logic                  busy
);

  localparam logic [INDEX_WIDTH-1:0] IDX_LAST      = '1;
  localparam logic [CONF_WIDTH-1:0]  CONF_THRESH_L = CONF_THRESH[CONF_WIDTH-1:0];

  vp_state_e              state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;

  logic                   pred_valid_q, pred_valid_d;
  logic                   pred_hit_q, pred_hit_d;
  logic                   pred_confident_q, pred_confident_d;
  logic [DATA_WIDTH-1:0]  pred_value_q, pred_value_d;

  logic [INDEX_WIDTH-1:0]  lk_idx, tr_idx;
  logic [VP_TAG_WIDTH-1:0] lk_tag, tr_tag;
  vp_entry_t               lk_entry, tr_entry, upd_entry, resp_src, wr_data;
  logic                    wr_en;
  logic [INDEX_WIDTH-1:0]  wr_idx;
  logic                    train_apply, train_hit, resp_forced, resp_hit;
  logic                    unused_pc_bits;

  assign lk_idx = lookup_pc[INDEX_WIDTH+1:2];
  assign lk_tag = lookup_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign tr_idx = train_pc[INDEX_WIDTH+1:2];
  assign tr_tag = train_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];

  assign unused_pc_bits = ^{lookup_pc[1:0], train_pc[1:0]};

  // Lookup and training both need a read in the same cycle, so the table is
  // kept as two identical copies fed by the same write stream.
  vp_table_ram #(.INDEX_WIDTH(INDEX_WIDTH)) u_lookup_bank (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (lk_idx),
    .rd_data (lk_entry)
  );

  vp_table_ram #(.INDEX_WIDTH(INDEX_WIDTH)) u_train_bank (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (tr_idx),
    .rd_data (tr_entry)
  );

  // FSM and sweep index registers; reset starts a fresh sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VP_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: flush always (re)starts the sweep; the sweep ends after the last index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = VP_CLEAR;
      idx_d   = '0;
    end else if (state_q == VP_CLEAR) begin
      if (idx_q == IDX_LAST) begin
        state_d = VP_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  assign busy        = (state_q == VP_CLEAR);
  assign train_apply = train_valid && (state_q == VP_IDLE) && !flush;
  assign resp_forced = (state_q == VP_CLEAR) || flush;

  // Training read-modify-write: repeat of the same value builds confidence, anything else resets it.
  always_comb begin
    train_hit       = tr_entry.valid && (tr_entry.tag == tr_tag);
    upd_entry       = '0;
    upd_entry.valid = 1'b1;
    upd_entry.tag   = tr_tag;
    upd_entry.value = train_value;
    upd_entry.conf  = '0;
    if (train_hit && (tr_entry.value == train_value)) begin
      upd_entry.conf = conf_sat_inc(tr_entry.conf);
    end
  end

  // Write port mux: the clear sweep takes priority over training.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = tr_idx;
    wr_data = upd_entry;
    if (state_q == VP_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = idx_q;
      wr_data = '0;
    end else if (train_apply) begin
      wr_en = 1'b1;
    end
  end

  // Lookup response: forced to a miss while clearing or flushing.
  always_comb begin
    resp_src = lk_entry;
`ifdef LOAD_VALUE_TABLE_BYPASS_EN
    if (train_apply && (tr_idx == lk_idx)) begin
      resp_src = upd_entry;
    end
`endif
    resp_hit         = resp_src.valid && (resp_src.tag == lk_tag);
    pred_valid_d     = lookup_valid;
    pred_hit_d       = 1'b0;
    pred_confident_d = 1'b0;
    pred_value_d     = '0;
    if (lookup_valid && !resp_forced && resp_hit) begin
      pred_hit_d       = 1'b1;
      pred_confident_d = (resp_src.conf >= CONF_THRESH_L);
      pred_value_d     = resp_src.value;
    end
  end

  // Response register giving the one-cycle lookup latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q     <= 1'b0;
      pred_hit_q       <= 1'b0;
      pred_confident_q <= 1'b0;
      pred_value_q     <= '0;
    end else begin
      pred_valid_q     <= pred_valid_d;
      pred_hit_q       <= pred_hit_d;
      pred_confident_q <= pred_confident_d;
      pred_value_q     <= pred_value_d;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_hit       = pred_hit_q;
  assign pred_confident = pred_confident_q;
  assign pred_value     = pred_value_q;

endmodule

// File: tb/tb_load_value_table.sv
// Scoreboard bench for load_value_table: a table-level model predicts every
// lookup response and the busy flag; a monitor compares responses as they appear.
module tb_load_value_table;

  localparam int ENTRIES = 64;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_confident;
  logic [31:0] pred_value;
  logic        train_valid;
  logic [31:0] train_pc;
  logic [31:0] train_value;
  logic        busy;

  typedef struct {
    bit          forced;
    bit          hit;
    bit          conf;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_val   [ENTRIES];
  int          m_conf  [ENTRIES];
  int          busy_left;

  int n_vectors;
  int n_miscompares;

  load_value_table dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .pred_valid     (pred_valid),
    .pred_hit       (pred_hit),
    .pred_confident (pred_confident),
    .pred_value     (pred_value),
    .train_valid    (train_valid),
    .train_pc       (train_pc),
    .train_value    (train_value),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table model: everything invalid at once, busy for one cycle per entry.
  task automatic model_invalidate();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_conf[i]  = 0;
    end
    busy_left = ENTRIES;
  endtask

  task automatic model_train(input logic [31:0] pc, input logic [31:0] val);
    int          i;
    int unsigned t;
    i = int'((pc >> 2) % ENTRIES);
    t = pc >> 8;
    if (m_valid[i] && m_tag[i] == t) begin
      if (m_val[i] == val) m_conf[i] = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
      else begin
        m_val[i]  = val;
        m_conf[i] = 0;
      end
    end else begin
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_val[i]   = val;
      m_conf[i]  = 0;
    end
  endtask

  function automatic exp_t model_lookup(input logic [31:0] pc, input bit forced);
    exp_t        e;
    int          i;
    int unsigned t;
    i = int'((pc >> 2) % ENTRIES);
    t = pc >> 8;
    e.forced = forced;
    e.hit    = !forced && m_valid[i] && m_tag[i] == t;
    e.conf   = e.hit && m_conf[i] >= 3;
    e.value  = e.hit ? m_val[i] : 32'h0;
    return e;
  endfunction

  task automatic report(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vectors++;
    if (got !== want) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  // One cycle of stimulus, issued at a falling edge.
  task automatic apply_stimulus(input bit lv, input logic [31:0] lpc, input bit tv,
                                input logic [31:0] tpc, input logic [31:0] tval, input bit fl);
    bit   forced;
    exp_t e;
    report("busy", {31'b0, busy}, {31'b0, busy_left > 0});
    lookup_valid = lv;
    lookup_pc    = lpc;
    train_valid  = tv;
    train_pc     = tpc;
    train_value  = tval;
    flush        = fl;
    forced = (busy_left > 0) || fl;
`ifdef LOAD_VALUE_TABLE_BYPASS_EN
    if (tv && !forced) model_train(tpc, tval);
    e = model_lookup(lpc, forced);
`else
    e = model_lookup(lpc, forced);
    if (tv && !forced) model_train(tpc, tval);
`endif
    if (lv) exp_q.push_back(e);
    if (fl) model_invalidate();
    else if (busy_left > 0) busy_left--;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    apply_stimulus(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] val);
    apply_stimulus(1'b0, 32'h0, 1'b1, pc, val, 1'b0);
  endtask

  // Reset state of the outputs, checked while reset is held.
  task automatic check_output();
    report("rst_pred_valid", {31'b0, pred_valid}, 32'h0);
    report("rst_pred_hit", {31'b0, pred_hit}, 32'h0);
    report("rst_pred_conf", {31'b0, pred_confident}, 32'h0);
    report("rst_pred_value", pred_value, 32'h0);
    report("rst_busy", {31'b0, busy}, 32'h1);
  endtask

  task automatic do_reset();
    idle(1);
    rst_n = 1'b0;
    model_invalidate();
    repeat (2) @(negedge clk);
    check_output();
    rst_n = 1'b1;
  endtask

  // Monitor: compares each response against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pred_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          report("unexpected_pred_valid", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          report("pred_hit", {31'b0, pred_hit}, {31'b0, e.hit});
          report("pred_confident", {31'b0, pred_confident}, {31'b0, e.conf});
          if (e.hit || e.forced) report("pred_value", pred_value, e.value);
        end
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        report("missing_pred_valid", {31'b0, pred_valid}, 32'h1);
      end
    end
  end

  initial begin
    logic [31:0] pc_a, pc_b, val;
    logic [31:0] vpool [3];
    n_vectors     = 0;
    n_miscompares = 0;
    rst_n        = 1'b1;
    flush        = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc    = '0;
    train_valid  = 1'b0;
    train_pc     = '0;
    train_value  = '0;
    model_invalidate();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output();
    rst_n = 1'b1;

    // Initial sweep, with a lookup landing in cycle 10 of it.
    idle(10);
    lookup(32'h400);
    idle(60);

    // Confidence build-up on pc 0x400, then a value change.
    for (int n = 0; n < 4; n++) begin
      train(32'h400, 32'hDEADBEEF);
      lookup(32'h400);
    end
    train(32'h400, 32'h00001234);
    lookup(32'h400);

    // Aliasing on index 0.
    train(32'h500, 32'hCAFEF00D);
    lookup(32'h400);
    lookup(32'h500);

    // Same-cycle train and lookup on an empty entry, then a plain lookup.
    apply_stimulus(1'b1, 32'h404, 1'b1, 32'h404, 32'h0BADF00D, 1'b0);
    lookup(32'h404);

    // Flush, re-flush 10 cycles in, trains dropped during the sweep.
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int n = 0; n < 9; n++) apply_stimulus(1'b1, 32'h500, 1'b1, 32'h500, 32'h77, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int n = 0; n < 66; n++) apply_stimulus(1'b0, 32'h0, 1'b1, 32'h600, 32'h99, 1'b0);
    lookup(32'h500);
    lookup(32'h404);
    lookup(32'h600);

    // Randomized traffic over a small pc/value space so entries get reused.
    vpool[0] = 32'h11111111;
    vpool[1] = 32'hAAAA5555;
    for (int n = 0; n < 3000; n++) begin
      vpool[2] = $urandom;
      pc_a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      pc_b = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 3) == 0) pc_b = pc_a;
      val = ($urandom_range(0, 7) == 0) ? vpool[2] : vpool[$urandom_range(0, 1)];
      apply_stimulus($urandom_range(0, 1) == 1, pc_a, $urandom_range(0, 3) != 0, pc_b, val,
                     $urandom_range(0, 399) == 0);
    end

    // Reset in the middle of a sweep restarts it from the beginning.
    train(32'h700, 32'h5A5A5A5A);
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle(20);
    do_reset();
    idle(63);
    lookup(32'h700);
    idle(1);
    train(32'h700, 32'h5A5A5A5A);
    lookup(32'h700);
    idle(3);

    report("scoreboard_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
